// File: rtl/nbit_mux_arbiter_pkg.sv
// rtl/nbit_mux_arbiter_pkg.sv - shared types and constants for the round-robin mux arbiter
package nbit_mux_arbiter_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // One-hot acknowledge for a channel index
  function automatic logic [NUM_CH-1:0] onehot_ch(input logic [1:0] idx);
    onehot_ch = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/nbit_mux_arbiter_mux4.sv
// rtl/nbit_mux_arbiter_mux4.sv - n-bit 4-to-1 data multiplexer
module nbit_mux4 #(
  parameter int N = 4
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [1:0]   sel,
  output logic [N-1:0] y
);

  // Plain index-driven select
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/nbit_mux_arbiter_rr_picker.sv
// rtl/nbit_mux_arbiter_rr_picker.sv - combinational round-robin winner selection
module rr_picker
  import nbit_mux_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last,
  output logic [1:0]        winner,
  output logic              any
);

  logic [1:0] idx;

  // Scan from the farthest candidate back to last+1 so the nearest set bit after last wins
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nbit_mux_arbiter.sv
// rtl/nbit_mux_arbiter.sv - four-channel round-robin arbiter with registered mux output
module nbit_mux_arbiter
  import nbit_mux_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic [N-1:0]      A,
  input  logic [N-1:0]      B,
  input  logic [N-1:0]      C,
  input  logic [N-1:0]      D,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [N-1:0]      Y,
  output logic [1:0]        S,
  output logic [NUM_CH-1:0] grant
);

  arb_state_e        state_q, state_d;
  logic [N-1:0]      y_q, y_d;
  logic [1:0]        s_q, s_d;
  logic [1:0]        last_q, last_d;
  logic [NUM_CH-1:0] grant_q, grant_d;

  logic [1:0]        pick;
  logic              pick_any;
  logic [N-1:0]      mux_y;
  logic              capture;

  rr_picker u_picker (
    .req    (req),
    .last   (last_q),
    .winner (pick),
    .any    (pick_any)
  );

  nbit_mux4 #(.N(N)) u_mux (
    .d0  (A),
    .d1  (B),
    .d2  (C),
    .d3  (D),
    .sel (pick),
    .y   (mux_y)
  );

  // State and datapath registers; last resets to 3 so channel 0 is first in line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      s_q     <= 2'b00;
      last_q  <= 2'b11;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      s_q     <= s_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Next state: HOLD stays put under backpressure, otherwise follows whether anyone is requesting
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = HOLD;
      HOLD:    if (out_ready) state_d = pick_any ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture happens whenever the output slot is free or being drained this edge
  always_comb begin
    capture = pick_any && ((state_q == IDLE) || out_ready);
    y_d     = y_q;
    s_d     = s_q;
    last_d  = last_q;
    grant_d = '0;
    if (capture) begin
      y_d     = mux_y;
      s_d     = pick;
      last_d  = pick;
      grant_d = onehot_ch(pick);
    end
  end

  assign out_valid = (state_q == HOLD);
  assign Y         = y_q;
  assign S         = s_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_nbit_mux_arbiter.sv
// tb/tb_nbit_mux_arbiter.sv - randomized self-checking bench with behavioural arbiter model
module tb_nbit_mux_arbiter;
  import nbit_mux_arbiter_pkg::*;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [W-1:0]  A, B, C, D;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  Y;
  logic [1:0]    S;
  logic [3:0]    grant;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit            m_valid;
  logic [W-1:0]  m_y;
  int            m_s;
  int            m_last;
  logic [3:0]    m_grant;
  int            m_win;

  nbit_mux_arbiter #(.N(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .Y         (Y),
    .S         (S),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_y     = '0;
    m_s     = 0;
    m_last  = 3;
    m_grant = '0;
    m_win   = -1;
  endtask

  // Behavioural rule: a capture happens when someone requests and the slot is empty or being taken
  task automatic model_edge(input logic [3:0] r, input logic rdy);
    logic [W-1:0] ch [4];
    ch[0] = A; ch[1] = B; ch[2] = C; ch[3] = D;
    m_grant = '0;
    m_win   = -1;
    if (r != 0 && (!m_valid || rdy)) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (m_win < 0 && r[(m_last + k) % NUM_CH]) m_win = (m_last + k) % NUM_CH;
      end
      m_y     = ch[m_win];
      m_s     = m_win;
      m_last  = m_win;
      m_grant = 4'(1 << m_win);
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".y"},     32'(Y),         32'(m_y));
    check({tag, ".s"},     32'(S),         32'(m_s));
    check({tag, ".grant"}, 32'(grant),     32'(m_grant));
    check({tag, ".state"}, 32'(dut.state_q), 32'(m_valid ? HOLD : IDLE));
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic rdy);
    @(negedge clk);
    req       = r;
    out_ready = rdy;
    model_edge(r, rdy);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge arrives
  task automatic reset_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    model_reset();
    check({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".rst_y"},     32'(Y),         32'd0);
    check({tag, ".rst_s"},     32'(S),         32'd0);
    check({tag, ".rst_grant"}, 32'(grant),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] rot [5];
    logic [3:0]   rr;
    rot[0] = 8'h11; rot[1] = 8'h22; rot[2] = 8'h33; rot[3] = 8'h44; rot[4] = 8'h11;

    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    A = '0; B = '0; C = '0; D = '0;
    model_reset();
    @(posedge clk); #1;
    reset_pulse("init");
    step("idle0", 4'b0000, 1'b0);

    // single request on channel C
    C = 8'h3C;
    step("single", 4'b0100, 1'b1);
    check("single.y_const", 32'(Y), 32'h3C);
    check("single.g_const", 32'(grant), 32'b0100);
    step("single_drain", 4'b0000, 1'b1);
    check("drain.y_keep", 32'(Y), 32'h3C);

    // full rotation from fresh reset
    @(posedge clk); #1;
    reset_pulse("rot");
    A = 8'h11; B = 8'h22; C = 8'h33; D = 8'h44;
    for (int i = 0; i < 5; i++) begin
      step("rot", 4'b1111, 1'b1);
      check("rot.y_seq", 32'(Y), 32'(rot[i]));
      check("rot.g_seq", 32'(grant), 32'(1 << (i % 4)));
    end
    step("rot_drain", 4'b0000, 1'b1);

    // backpressure while holding B
    @(posedge clk); #1;
    reset_pulse("bp");
    B = 8'h22;
    step("bp_cap", 4'b0010, 1'b1);
    B = 8'h99;
    for (int i = 0; i < 5; i++) begin
      step("bp", 4'($urandom_range(0, 15)), 1'b0);
      check("bp.y_const", 32'(Y), 32'h22);
    end
    step("bp_drain", 4'b0000, 1'b1);

    // wrap and skip from last=3
    @(posedge clk); #1;
    reset_pulse("wrap");
    step("wrap1", 4'b1010, 1'b1);
    check("wrap1.s", 32'(S), 32'd1);
    step("wrap3", 4'b1010, 1'b1);
    check("wrap3.s", 32'(S), 32'd3);
    step("wrap0", 4'b0001, 1'b1);
    check("wrap0.s", 32'(S), 32'd0);
    step("wrap_drain", 4'b0000, 1'b1);

    // reset while holding A5
    A = 8'hA5;
    step("hold_a5", 4'b0001, 1'b0);
    check("hold_a5.y", 32'(Y), 32'hA5);
    reset_pulse("midhold");
    step("post_rst", 4'b0000, 1'b1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      A = W'($urandom); B = W'($urandom); C = W'($urandom); D = W'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      step("rand", rr, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 59) == 0) reset_pulse("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nbit_mux_arbiter.md
NBIT_MUX_ARBITER -- requirements
Module: nbit_mux_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, data width of each requester channel and of the output.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 4 bits, per-requester request; bit i belongs to channel i (0=A, 1=B, 2=C, 3=D).
REQ-005 SHALL have ports A, B, C, D, input, N bits each, requester data channels 0..3.
REQ-006 SHALL have port out_ready, input, 1 bit, downstream accepts Y when high with out_valid.
REQ-007 SHALL have port out_valid, output, 1 bit, Y holds a granted word.
REQ-008 SHALL have port Y, output, N bits, registered data of the granted channel.
REQ-009 SHALL have port S, output, 2 bits, index of the channel currently held in Y.
REQ-010 SHALL have port grant, output, 4 bits, one-hot single-cycle acknowledge to the captured requester.

Function
REQ-011 SHALL implement FSM states IDLE (out_valid=0) and HOLD (out_valid=1); no other states.
REQ-012 In IDLE with req==0, SHALL remain in IDLE with all outputs unchanged and grant=0.
REQ-013 In IDLE with req!=0, SHALL choose the winner round-robin: first set req bit searching upward from (last+1) mod 4, wrapping 3->0.
REQ-014 On capture, SHALL register Y=data of winner, S=winner index, last=winner, grant=one-hot(winner), go to HOLD; latency one clock from req sampled to out_valid high.
REQ-015 grant SHALL be high for exactly the one cycle following each capture edge and 0 otherwise.
REQ-016 In HOLD with out_ready=0, SHALL keep Y, S, out_valid stable regardless of req or channel data changes.
REQ-017 In HOLD with out_ready=1 and req==0, SHALL return to IDLE (out_valid=0 next cycle).
REQ-018 In HOLD with out_ready=1 and req!=0, SHALL capture the next round-robin winner in the same edge and remain in HOLD (back-to-back, no bubble).
REQ-019 With req=4'b1111 continuously and out_ready=1, grants SHALL rotate 0,1,2,3,0,... one per cycle.
REQ-020 A requester whose req drops while another is held SHALL not be granted; a request is only sampled when a capture occurs.
REQ-021 A single requester asserting continuously SHALL be granted every capture (no forced idle gap).
REQ-022 last SHALL update only on capture; acceptance without new capture SHALL leave last unchanged.

Reset
REQ-023 On rst_n low, SHALL asynchronously force state=IDLE, out_valid=0, Y=0, S=2'b00, grant=4'b0000, last=2'b11 (so channel 0 has first priority).
REQ-024 Reset asserted in HOLD SHALL discard the held word; no grant or out_valid SHALL appear until a req is sampled after rst_n returns high.

Structure
REQ-025 State encodings (IDLE, HOLD) and channel count constant 4 SHALL live in a shared package used by this block and its bench.
REQ-026 Round-robin priority selection SHALL be a combinational sub-module rr_picker (inputs req, last; outputs winner index, any); data selection SHALL use the team's n-bit 4-to-1 mux driven by the picker index.

Verification
REQ-027 Reset: rst_n=0 mid-HOLD with Y=8'hA5 -> out_valid=0, Y=0, S=0, grant=0 immediately, without waiting for clk.
REQ-028 Single request: N=8, req=4'b0100, C=8'h3C, out_ready=1 -> one cycle later out_valid=1, Y=8'h3C, S=2, grant=4'b0100 for one cycle.
REQ-029 Full rotation: req=4'b1111, A..D=8'h11/22/33/44, out_ready=1 -> Y sequence 11,22,33,44,11 on consecutive cycles, grant one-hot rotating.
REQ-030 Backpressure: HOLD with Y=8'h22, out_ready=0 for 5 cycles while B changes to 8'h99 -> Y stays 8'h22, grant=0, S=1 throughout.
REQ-031 Wrap/skip: last=3, req=4'b1010 -> winner 1; then req=4'b1010 again -> winner 3; then req=4'b0001 -> winner 0.
REQ-032 Drain: HOLD, out_ready=1, req=0 -> out_valid=0 next cycle, state IDLE, Y retains last value.
